// File: rtl/maxnet_host_pkg.sv
// Shared types and defaults for the Maxnet host initiator.
// Holds the FSM state encoding and the default N/W also used by the Maxnet datapath.
// Optional feature macro used by the host files: MAXNET_HOST_TIMEOUT_EN.

package maxnet_host_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam int unsigned MAXNET_N = 4;
    localparam int unsigned MAXNET_W = 8;

    // Index width for an N-entry memory; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxnet_host_ctrl.sv
// Maxnet host control: run FSM, load counter and optional WAIT watchdog.
// Ports: clk/rst (async active-low), in_valid, mx_rise (completion edge),
//   res_ack in; in_ready, mx_start, res_valid, busy, accept, capture,
//   cnt out; timeout out only when MAXNET_HOST_TIMEOUT_EN is defined.

module maxnet_host_ctrl
    import maxnet_host_pkg::*;
#(
    parameter int unsigned N = MAXNET_N,
`ifdef MAXNET_HOST_TIMEOUT_EN
    parameter int unsigned TMO_CYCLES = 1024,
`endif
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          mx_rise,
    input  logic          res_ack,
`ifdef MAXNET_HOST_TIMEOUT_EN
    output logic          timeout,
`endif
    output logic [IW-1:0] cnt,
    output logic          in_ready,
    output logic          mx_start,
    output logic          res_valid,
    output logic          busy,
    output logic          accept,
    output logic          capture
);

    state_t state;
    logic   expire;

    // in_ready is registered and only ever high in LOAD.
    assign accept  = in_valid & in_ready;
    // Edges seen outside WAIT (e.g. during START) are dropped here.
    assign capture = (state == ST_WAIT) & mx_rise;
    assign busy    = !((state == ST_LOAD) && (cnt == '0));

`ifdef MAXNET_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    // A real completion in the last watchdog cycle wins over the timeout.
    assign expire  = (state == ST_WAIT) & ~mx_rise &
                     (tmo_cnt == TW'(TMO_CYCLES - 1));
    assign timeout = expire;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            in_ready  <= 1'b1;
            mx_start  <= 1'b0;
            res_valid <= 1'b0;
`ifdef MAXNET_HOST_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            mx_start <= 1'b0;
`ifdef MAXNET_HOST_TIMEOUT_EN
            // Held at zero outside WAIT, so it starts clean on entry.
            if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
`endif
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (cnt == IW'(N - 1)) begin
                            cnt      <= '0;
                            state    <= ST_START;
                            in_ready <= 1'b0;
                            mx_start <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture || expire) begin
                        state     <= ST_RESULT;
                        res_valid <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ack) begin
                        state     <= ST_LOAD;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: rtl/maxnet_host.sv
// Host-side initiator for the Maxnet engine: loads N words, pulses start,
// captures the winner on the rising edge of mx_ready and hands it upstream.
// Ports: clk/rst (async active-low); in_valid/in_data/in_ready upstream;
//   load_we/load_addr/load_data to the input memory; mx_start, mx_ready,
//   mx_win_idx, mx_win_val to Maxnet; res_valid/res_idx/res_val/res_err/
//   res_ack downstream; busy status.
// Optional watchdog: define MAXNET_HOST_TIMEOUT_EN (uses TMO_CYCLES).

module maxnet_host
    import maxnet_host_pkg::*;
#(
    parameter int unsigned N = MAXNET_N,
    parameter int unsigned W = MAXNET_W,
`ifdef MAXNET_HOST_TIMEOUT_EN
    parameter int unsigned TMO_CYCLES = 1024,
`endif
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          load_we,
    output logic [IW-1:0] load_addr,
    output logic [W-1:0]  load_data,
    output logic          mx_start,
    input  logic          mx_ready,
    input  logic [IW-1:0] mx_win_idx,
    input  logic [W-1:0]  mx_win_val,
    output logic          res_valid,
    output logic [IW-1:0] res_idx,
    output logic [W-1:0]  res_val,
    output logic          res_err,
    input  logic          res_ack,
    output logic          busy
);

    logic          mx_ready_q;
    logic          mx_rise;
    logic          accept;
    logic          capture;
    logic [IW-1:0] cnt;

    // A level left high from the previous run never looks like an edge.
    assign mx_rise = mx_ready & ~mx_ready_q;

`ifdef MAXNET_HOST_TIMEOUT_EN
    logic timeout;
    logic err_q;

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    maxnet_host_ctrl #(
        .N          (N)
`ifdef MAXNET_HOST_TIMEOUT_EN
        ,
        .TMO_CYCLES (TMO_CYCLES)
`endif
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mx_rise   (mx_rise),
        .res_ack   (res_ack),
`ifdef MAXNET_HOST_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .cnt       (cnt),
        .in_ready  (in_ready),
        .mx_start  (mx_start),
        .res_valid (res_valid),
        .busy      (busy),
        .accept    (accept),
        .capture   (capture)
    );

    // Accepted words are written one cycle later, so the final write
    // lands in the same cycle as mx_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx_ready_q <= 1'b0;
            load_we    <= 1'b0;
            load_addr  <= '0;
            load_data  <= '0;
            res_idx    <= '0;
            res_val    <= '0;
`ifdef MAXNET_HOST_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            mx_ready_q <= mx_ready;
            load_we    <= accept;
            if (accept) begin
                load_addr <= cnt;
                load_data <= in_data;
            end
            if (capture) begin
                res_idx <= mx_win_idx;
                res_val <= mx_win_val;
`ifdef MAXNET_HOST_TIMEOUT_EN
                err_q   <= 1'b0;
            end else if (timeout) begin
                res_idx <= '0;
                res_val <= '0;
                err_q   <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_maxnet_host.sv
// Self-checking bench for maxnet_host (N=4, W=8): vector table for load,
// wait and result handshake, plus sequences for held mx_ready, reset and timeout.

module tb_maxnet_host;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       load_we;
    logic [1:0] load_addr;
    logic [7:0] load_data;
    logic       mx_start;
    logic       mx_ready;
    logic [1:0] mx_win_idx;
    logic [7:0] mx_win_val;
    logic       res_valid;
    logic [1:0] res_idx;
    logic [7:0] res_val;
    logic       res_err;
    logic       res_ack;
    logic       busy;

    int n_err;
    int n_chk;

`ifdef MAXNET_HOST_TIMEOUT_EN
    maxnet_host #(.N(4), .W(8), .TMO_CYCLES(16)) dut (
`else
    maxnet_host #(.N(4), .W(8)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .mx_start   (mx_start),
        .mx_ready   (mx_ready),
        .mx_win_idx (mx_win_idx),
        .mx_win_val (mx_win_val),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_val    (res_val),
        .res_err    (res_err),
        .res_ack    (res_ack),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       mr;
        logic [1:0] mi;
        logic [7:0] mv;
        logic       ack;
        logic       e_ir;
        logic       e_we;
        logic [1:0] e_addr;
        logic [7:0] e_data;
        logic       e_st;
        logic       e_rv;
        logic [1:0] e_ri;
        logic [7:0] e_rval;
        logic       e_busy;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] w[4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = w[k];
            step();
            chk($sformatf("ld%0d_we", k), load_we, 1);
            chk($sformatf("ld%0d_addr", k), load_addr, k);
            chk($sformatf("ld%0d_data", k), load_data, w[k]);
            chk($sformatf("ld%0d_start", k), mx_start, (k == 3) ? 1 : 0);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        mx_ready = 1'b0;
        mx_win_idx = 2'd0;
        mx_win_val = 8'h00;
        res_ack = 1'b0;

        //      iv id  mr mi mv  ack ir we ad dat st rv ri rval busy
        tv[0]  = '{1, 5,  0, 0, 0,   0, 1, 1, 0, 5,  0, 0, 0, 0, 1};
        tv[1]  = '{1, 9,  0, 0, 0,   0, 1, 1, 1, 9,  0, 0, 0, 0, 1};
        tv[2]  = '{1, 3,  0, 0, 0,   0, 1, 1, 2, 3,  0, 0, 0, 0, 1};
        tv[3]  = '{1, 7,  0, 0, 0,   0, 0, 1, 3, 7,  1, 0, 0, 0, 1};
        tv[4]  = '{1, 99, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        tv[5]  = '{0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        tv[6]  = '{1, 42, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        tv[7]  = '{0, 0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
        tv[8]  = '{1, 77, 1, 1, 4,   0, 0, 0, 0, 0,  0, 1, 1, 4, 1};
        tv[9]  = '{1, 66, 1, 2, 9,   0, 0, 0, 0, 0,  0, 1, 1, 4, 1};
        tv[10] = '{0, 0,  1, 2, 9,   1, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        tv[11] = '{0, 0,  0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        tv[12] = '{1, 11, 0, 0, 0,   0, 1, 1, 0, 11, 0, 0, 0, 0, 1};
        tv[13] = '{1, 22, 0, 0, 0,   0, 1, 1, 1, 22, 0, 0, 0, 0, 1};
        tv[14] = '{1, 33, 0, 0, 0,   0, 1, 1, 2, 33, 0, 0, 0, 0, 1};
        tv[15] = '{1, 44, 0, 0, 0,   0, 0, 1, 3, 44, 1, 0, 0, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_load_we", load_we, 0);
        chk("rst_mx_start", mx_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_val", res_val, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // Table: two back-to-back loads, wait with in_valid noise, result.
        for (int i = 0; i < 16; i++) begin
            in_valid   = tv[i].iv;
            in_data    = tv[i].id;
            mx_ready   = tv[i].mr;
            mx_win_idx = tv[i].mi;
            mx_win_val = tv[i].mv;
            res_ack    = tv[i].ack;
            step();
            chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].e_ir);
            chk($sformatf("v%0d_load_we", i), load_we, tv[i].e_we);
            if (tv[i].e_we) begin
                chk($sformatf("v%0d_load_addr", i), load_addr, tv[i].e_addr);
                chk($sformatf("v%0d_load_data", i), load_data, tv[i].e_data);
            end
            chk($sformatf("v%0d_mx_start", i), mx_start, tv[i].e_st);
            chk($sformatf("v%0d_res_valid", i), res_valid, tv[i].e_rv);
            if (tv[i].e_rv) begin
                chk($sformatf("v%0d_res_idx", i), res_idx, tv[i].e_ri);
                chk($sformatf("v%0d_res_val", i), res_val, tv[i].e_rval);
                chk($sformatf("v%0d_res_err", i), res_err, 0);
            end
            chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
        end
        in_valid = 1'b0;
        res_ack  = 1'b0;

        // Now in START: mx_ready rises here and stays high -> no capture.
        mx_ready   = 1'b1;
        mx_win_idx = 2'd2;
        mx_win_val = 8'd200;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold%0d_res_valid", k), res_valid, 0);
            chk($sformatf("hold%0d_mx_start", k), mx_start, 0);
        end
        mx_ready = 1'b0;
        step();
        chk("drop_res_valid", res_valid, 0);
        mx_ready   = 1'b1;
        mx_win_idx = 2'd3;
        mx_win_val = 8'd250;
        step();
        chk("rerise_res_valid", res_valid, 1);
        chk("rerise_res_idx", res_idx, 3);
        chk("rerise_res_val", res_val, 250);
        chk("rerise_res_err", res_err, 0);
        mx_ready   = 1'b0;
        mx_win_idx = 2'd0;
        mx_win_val = 8'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stable%0d_res_valid", k), res_valid, 1);
            chk($sformatf("stable%0d_res_idx", k), res_idx, 3);
            chk($sformatf("stable%0d_res_val", k), res_val, 250);
            chk($sformatf("stable%0d_in_ready", k), in_ready, 0);
        end
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        chk("ack1_res_valid", res_valid, 0);
        chk("ack1_in_ready", in_ready, 1);

        // Completion 10 cycles after start; in_valid held high meanwhile.
        load4(8'd5, 8'd9, 8'd3, 8'd7);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("w10_%0d_load_we", k), load_we, 0);
            chk($sformatf("w10_%0d_res_valid", k), res_valid, 0);
        end
        mx_ready   = 1'b1;
        mx_win_idx = 2'd1;
        mx_win_val = 8'd4;
        step();
        chk("w10_res_valid", res_valid, 1);
        chk("w10_res_idx", res_idx, 1);
        chk("w10_res_val", res_val, 4);
        chk("w10_res_err", res_err, 0);
        chk("w10_load_we", load_we, 0);
        step();
        chk("w10_hold_res_valid", res_valid, 1);
        chk("w10_hold_in_ready", in_ready, 0);
        in_valid = 1'b0;
        res_ack  = 1'b1;
        step();
        res_ack  = 1'b0;
        mx_ready = 1'b0;
        chk("ack2_res_valid", res_valid, 0);
        chk("ack2_in_ready", in_ready, 1);
        chk("ack2_busy", busy, 0);

        // Reset asserted while waiting.
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        step();
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_load_we", load_we, 0);
        chk("arst_load_addr", load_addr, 0);
        chk("arst_load_data", load_data, 0);
        chk("arst_mx_start", mx_start, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_idx", res_idx, 0);
        chk("arst_res_val", res_val, 0);
        chk("arst_res_err", res_err, 0);
        chk("arst_busy", busy, 0);
        step();
        chk("arst2_in_ready", in_ready, 1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst%0d_mx_start", k), mx_start, 0);
            chk($sformatf("post_rst%0d_busy", k), busy, 0);
        end
        load4(8'd8, 8'd6, 8'd250, 8'd1);
        step();
        step();
        mx_ready   = 1'b1;
        mx_win_idx = 2'd2;
        mx_win_val = 8'd250;
        step();
        chk("clean_res_valid", res_valid, 1);
        chk("clean_res_idx", res_idx, 2);
        chk("clean_res_val", res_val, 250);
        res_ack = 1'b1;
        step();
        res_ack  = 1'b0;
        mx_ready = 1'b0;
        chk("clean_ack_in_ready", in_ready, 1);

`ifdef MAXNET_HOST_TIMEOUT_EN
        // Watchdog: 16 cycles in WAIT, then an error result.
        load4(8'd1, 8'd1, 8'd1, 8'd1);
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("tmo%0d_res_valid", k), res_valid, 0);
        end
        step();
        chk("tmo_res_valid", res_valid, 1);
        chk("tmo_res_err", res_err, 1);
        chk("tmo_res_idx", res_idx, 0);
        chk("tmo_res_val", res_val, 0);
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
        chk("tmo_ack_in_ready", in_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
